// File: rtl/lfsr_scrambler_gen3_multi.sv
// Multi-lane 128b/130b scrambler/descrambler with one 23-bit Galois LFSR per lane.
// Each byte can be skipped or bypassed, each lane can be re-seeded, and scrambling can be disabled globally.
module lfsr_scrambler_gen3_multi #(
  parameter int LANES     = 4,
  parameter int BYTES     = 2,
  parameter int LANE_BASE = 0
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [LANES*BYTES*8-1:0] in_data,
  input  logic [LANES*BYTES-1:0]   in_skip,
  input  logic [LANES*BYTES-1:0]   in_bypass,
  input  logic [LANES-1:0]         seed_reset,
  input  logic                     scramble_dis,
  output logic                     out_valid,
  output logic [LANES*BYTES*8-1:0] out_data
);

  function automatic logic [22:0] lane_seed(input int lane);
    logic [2:0]  sel;
    logic [23:0] raw;
    sel = 3'((LANE_BASE + lane) % 8);
    case (sel)
      3'd0:    raw = 24'h1DBFBC;
      3'd1:    raw = 24'h0607BB;
      3'd2:    raw = 24'h1EC760;
      3'd3:    raw = 24'h18C0DB;
      3'd4:    raw = 24'h010F12;
      3'd5:    raw = 24'h19CFC9;
      3'd6:    raw = 24'h0277CE;
      default: raw = 24'h1BB807;
    endcase
    return raw[22:0];
  endfunction

  // One serial step of X^23+X^21+X^16+X^8+X^5+X^2+1; the bit shifted out feeds back into the taps.
  function automatic logic [22:0] lfsr_step(input logic [22:0] s);
    logic        fb;
    logic [22:0] n;
    fb    = s[22];
    n     = {s[21:0], fb};
    n[2]  = n[2]  ^ fb;
    n[5]  = n[5]  ^ fb;
    n[8]  = n[8]  ^ fb;
    n[16] = n[16] ^ fb;
    n[21] = n[21] ^ fb;
    return n;
  endfunction

  function automatic logic [22:0] advance8(input logic [22:0] s);
    logic [22:0] w;
    w = s;
    for (int i = 0; i < 8; i++) begin
      w = lfsr_step(w);
    end
    return w;
  endfunction

  // Keystream bit i is the bit shifted out on step i; it scrambles data bit i.
  function automatic logic [7:0] key_byte(input logic [22:0] s);
    logic [22:0] w;
    logic [7:0]  k;
    w = s;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = w[22];
      w    = lfsr_step(w);
    end
    return k;
  endfunction

  logic [22:0]              state_r [LANES];
  logic [22:0]              state_nxt_s [LANES];
  logic [LANES*BYTES*8-1:0] data_nxt_s;
  logic                     out_valid_r;
  logic [LANES*BYTES*8-1:0] out_data_r;

  // Walk each lane's LFSR across its bytes in order, producing output bytes and the next lane state.
  always_comb begin : scramble_comb
    logic [22:0] walk;
    walk       = 23'h000000;
    data_nxt_s = in_data;
    for (int l = 0; l < LANES; l++) begin
      walk           = state_r[l];
      state_nxt_s[l] = state_r[l];
      for (int b = 0; b < BYTES; b++) begin
        if (in_skip[l*BYTES+b]) begin
          data_nxt_s[(l*BYTES+b)*8 +: 8] = in_data[(l*BYTES+b)*8 +: 8];
        end else begin
          if (in_bypass[l*BYTES+b] || scramble_dis) begin
            data_nxt_s[(l*BYTES+b)*8 +: 8] = in_data[(l*BYTES+b)*8 +: 8];
          end else begin
            data_nxt_s[(l*BYTES+b)*8 +: 8] = in_data[(l*BYTES+b)*8 +: 8] ^ key_byte(walk);
          end
          walk = advance8(walk);
        end
      end
      // A re-seed wins over this beat's advance; the beat itself still used the old state.
      if (seed_reset[l]) begin
        state_nxt_s[l] = lane_seed(l);
      end else if (in_valid) begin
        state_nxt_s[l] = walk;
      end else begin
        state_nxt_s[l] = state_r[l];
      end
    end
  end

  // Lane state and registered outputs; reset reloads every seed and clears the output.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        state_r[l] <= lane_seed(l);
      end
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        state_r[l] <= state_nxt_s[l];
      end
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_data_r <= data_nxt_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_lfsr_scrambler_gen3_multi.sv
// Bench: scrambler checked against a keystream-position model, a descrambler round trip,
// and a second configuration (1 byte/lane, LANE_BASE=6) exercising seed wrap-around.
module tb_lfsr_scrambler_gen3_multi;

  localparam int KSN = 32768;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst;
  logic        a_valid, a_dis, a_ov;
  logic [63:0] a_data, a_od;
  logic [7:0]  a_skip, a_byp;
  logic [3:0]  a_sr;
  logic        b_valid, b_dis, b_ov;
  logic [63:0] b_data, b_od;
  logic [7:0]  b_skip, b_byp;
  logic [3:0]  b_sr;
  logic        c_valid, c_dis, c_ov;
  logic [31:0] c_data, c_od;
  logic [3:0]  c_skip, c_byp;
  logic [3:0]  c_sr;

  lfsr_scrambler_gen3_multi #(.LANES(4), .BYTES(2), .LANE_BASE(0)) dut_a (
    .pclk(pclk), .reset(rst), .in_valid(a_valid), .in_data(a_data), .in_skip(a_skip),
    .in_bypass(a_byp), .seed_reset(a_sr), .scramble_dis(a_dis), .out_valid(a_ov), .out_data(a_od));

  lfsr_scrambler_gen3_multi #(.LANES(4), .BYTES(2), .LANE_BASE(0)) dut_b (
    .pclk(pclk), .reset(rst), .in_valid(b_valid), .in_data(b_data), .in_skip(b_skip),
    .in_bypass(b_byp), .seed_reset(b_sr), .scramble_dis(b_dis), .out_valid(b_ov), .out_data(b_od));

  lfsr_scrambler_gen3_multi #(.LANES(4), .BYTES(1), .LANE_BASE(6)) dut_c (
    .pclk(pclk), .reset(rst), .in_valid(c_valid), .in_data(c_data), .in_skip(c_skip),
    .in_bypass(c_byp), .seed_reset(c_sr), .scramble_dis(c_dis), .out_valid(c_ov), .out_data(c_od));

  logic [23:0] seeds [8] = '{24'h1DBFBC, 24'h0607BB, 24'h1EC760, 24'h18C0DB,
                             24'h010F12, 24'h19CFC9, 24'h0277CE, 24'h1BB807};
  bit          ks [8][KSN];
  int          pos [2][4];
  logic        ev [2];
  logic [63:0] ed [2];
  logic        eb_v;
  logic [63:0] eb_d;
  logic        pa_valid, pa_rst, pa_dis;
  logic [63:0] pa_data;
  logic [7:0]  pa_skip, pa_byp;
  logic [3:0]  pa_sr;
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ksbyte(input int si, input int p);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (p + i < KSN) r[i] = ks[si][p+i];
    end
    return r;
  endfunction

  function automatic logic [15:0] rmask(input int n, input int den);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < n; i++) r[i] = ($urandom_range(0, den - 1) == 0);
    return r;
  endfunction

  // Each lane is a read position into its seed's keystream; scrambled/bypassed bytes consume 8 bits.
  task automatic model_beat(input int k, input int nb, input int base, input logic v, input logic r,
                            input logic [63:0] d, input logic [15:0] sk, input logic [15:0] bp,
                            input logic [3:0] sr, input logic dis);
    logic [63:0] o;
    logic [7:0]  byt;
    int          si, idx;
    if (r) begin
      for (int l = 0; l < 4; l++) pos[k][l] = 0;
      ev[k] = 1'b0;
      ed[k] = 64'h0;
    end else begin
      o = ed[k];
      for (int l = 0; l < 4; l++) begin
        si = (base + l) % 8;
        if (v) begin
          for (int b = 0; b < nb; b++) begin
            idx = l * nb + b;
            byt = d[idx*8 +: 8];
            if (sk[idx]) begin
              o[idx*8 +: 8] = byt;
            end else begin
              o[idx*8 +: 8] = (bp[idx] || dis) ? byt : (byt ^ ksbyte(si, pos[k][l]));
              pos[k][l] += 8;
            end
          end
        end
        if (sr[l]) pos[k][l] = 0;
      end
      ev[k] = v;
      if (v) ed[k] = o;
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    #2;
  endtask

  // Drive one beat: descrambler gets the previous scrambler beat, and the model predicts all outputs.
  task automatic apply();
    b_valid = a_ov;
    b_data  = a_od;
    b_skip  = pa_skip;
    b_byp   = pa_byp;
    b_sr    = pa_sr;
    b_dis   = pa_dis;
    if (rst) begin
      eb_v = 1'b0;
      eb_d = 64'h0;
    end else if (pa_valid && !pa_rst) begin
      eb_v = 1'b1;
      eb_d = pa_data;
    end else begin
      eb_v = 1'b0;
    end
    model_beat(0, 2, 0, a_valid, rst, a_data, {8'h00, a_skip}, {8'h00, a_byp}, a_sr, a_dis);
    model_beat(1, 1, 6, c_valid, rst, {32'h0, c_data}, {12'h000, c_skip}, {12'h000, c_byp}, c_sr, c_dis);
    pa_valid = a_valid; pa_rst = rst; pa_data = a_data;
    pa_skip  = a_skip;  pa_byp = a_byp; pa_sr = a_sr; pa_dis = a_dis;
    chk_en = 1'b1;
    cycle();
  endtask

  task automatic rnd_beat(input bit allow_rst, input bit all_valid);
    rst     = allow_rst && ($urandom_range(0, 199) == 0);
    a_valid = all_valid || ($urandom_range(0, 4) != 0);
    a_data  = {$urandom, $urandom};
    a_skip  = rmask(8, 8);
    a_byp   = rmask(8, 8);
    a_sr    = rmask(4, 64);
    a_dis   = ($urandom_range(0, 15) == 0);
    c_valid = all_valid || ($urandom_range(0, 4) != 0);
    c_data  = $urandom;
    c_skip  = rmask(4, 8);
    c_byp   = rmask(4, 8);
    c_sr    = rmask(4, 64);
    c_dis   = ($urandom_range(0, 15) == 0);
  endtask

  task automatic clean_beat();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 64'h0; a_skip = 8'h00; a_byp = 8'h00; a_sr = 4'h0; a_dis = 1'b0;
    c_valid = 1'b1; c_data = 32'h0; c_skip = 4'h0; c_byp = 4'h0; c_sr = 4'h0; c_dis = 1'b0;
  endtask

  // Compare all three instances against their predictions once per cycle, just after the edge.
  always @(posedge pclk) begin
    #1;
    if (chk_en) begin
      chk("a_valid", 64'(a_ov), 64'(ev[0]));
      chk("a_data", a_od, ed[0]);
      chk("c_valid", 64'(c_ov), 64'(ev[1]));
      chk("c_data", {32'h0, c_od}, ed[1]);
      chk("rt_valid", 64'(b_ov), 64'(eb_v));
      chk("rt_data", b_od, eb_d);
    end
  end

  initial begin
    logic [22:0] s;
    logic        fb;
    for (int si = 0; si < 8; si++) begin
      s = seeds[si][22:0];
      for (int n = 0; n < KSN; n++) begin
        ks[si][n] = s[22];
        fb = s[22];
        s  = {s[21:0], fb} ^ (fb ? 23'h210124 : 23'h000000);
      end
    end
    pa_valid = 1'b0; pa_rst = 1'b1; pa_data = 64'h0;
    pa_skip = 8'h00; pa_byp = 8'h00; pa_sr = 4'h0; pa_dis = 1'b0;

    clean_beat();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply();

    clean_beat(); a_sr = 4'b0001;
    apply();
    chk("first_byte", 64'(a_od[7:0]), 64'h6C);
    chk("first_valid", 64'(a_ov), 64'h1);

    clean_beat(); a_skip = 8'h01; a_sr = 4'b0001;
    apply();
    chk("skip_b0", 64'(a_od[7:0]), 64'h00);
    chk("skip_b1", 64'(a_od[15:8]), 64'h6C);

    clean_beat(); a_byp = 8'h01; a_data = 64'hE1; a_sr = 4'b0001;
    apply();
    chk("byp_b0", 64'(a_od[7:0]), 64'hE1);

    clean_beat(); a_skip = 8'h01; a_byp = 8'h01; a_data = 64'h5A;
    apply();
    chk("both_b0", 64'(a_od[7:0]), 64'h5A);
    chk("both_b1", 64'(a_od[15:8]), 64'h6C);

    clean_beat();
    apply();
    for (int i = 0; i < 5; i++) begin rnd_beat(1'b0, 1'b1); a_sr = 4'h0; c_sr = 4'h0; apply(); end
    rnd_beat(1'b0, 1'b1); a_sr = 4'b0100; c_sr = 4'b0100;
    apply();
    for (int i = 0; i < 3; i++) begin rnd_beat(1'b0, 1'b1); a_sr = 4'h0; apply(); end

    for (int i = 0; i < 3; i++) begin
      rnd_beat(1'b0, 1'b1); a_dis = 1'b1; a_skip = 8'h00; a_byp = 8'h00; a_sr = 4'h0;
      apply();
      chk("dis_pass", a_od, a_data);
    end
    for (int i = 0; i < 2; i++) begin rnd_beat(1'b0, 1'b1); a_dis = 1'b0; apply(); end

    rnd_beat(1'b0, 1'b1); rst = 1'b1;
    apply();
    chk("rst_valid", 64'(a_ov), 64'h0);
    chk("rst_data", a_od, 64'h0);

    for (int i = 0; i < 1000; i++) begin rnd_beat(1'b1, 1'b0); apply(); end
    for (int i = 0; i < 3; i++) begin clean_beat(); a_valid = 1'b0; c_valid = 1'b0; apply(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
